hazard_ctrl: RTL and testbench

Pipeline hazard and stall sequencer for the 5-stage CPU. Drives the control-bubble select into the ID-stage control mux, and the PC and pipeline-register write enables. Handles three cases:
- load-use stalls
- branch/jump flushes of IF/ID
- multi-cycle data-memory waits, with a timeout watchdog

Sits beside the ID-stage decoder; its outputs gate the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.

---
 rtl/hazard_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard and stall sequencer for the 5-stage CPU.
//
// Drives the ID-stage control-bubble select and the write enables of PC, IF/ID,
// ID/EX, EX/MEM, plus the MEM/WB bubble. It covers load-use stalls, taken
// branch/jump flushes of IF/ID, and multi-cycle data-memory waits guarded by a
// timeout watchdog.
//
// Ports:
//   clk_i, rst_i            clock (rising edge), async active-high reset
//   IDEX_MemRd_i, IDEX_Rt_i load in EX and its destination register
//   IFID_Rs_i, IFID_Rt_i    source registers of the instruction in ID
//   Branch_taken_i          ID resolved a taken branch/jump
//   mem_req_i, mem_ack_i    data-memory request / completion
//   select_o                1 = ID control mux emits an all-zero bubble
//   PCWrite_o .. EXMEMWrite_o  register write enables
//   IFID_Flush_o            clear IF/ID at the next edge
//   MEMWB_bubble_o          load a bubble into MEM/WB
//   mem_timeout_o           sticky timeout error
//   state_o                 FSM state (debug)
//   stall_cycles_o, flush_count_o  perf counters
//
// Optional feature: define HAZARD_PERF_EN to build the saturating perf
// counters; otherwise both counter ports read 0 and no counter flops exist.
//
// state   | meaning
// --------+--------------------------------------------------------------
// RUN     | normal operation; load-use stalls and flushes handled here
// MEMWAIT | a data-memory access has been pending for at least one cycle
// ERR     | access never acked in time; pipeline parked until reset

module hazard_ctrl #(
  parameter int MAX_MEM_WAIT = 15,
  parameter int WAIT_CNT_W   = 4,
  parameter int PERF_W       = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              IDEX_MemRd_i,
  input  logic [4:0]        IDEX_Rt_i,
  input  logic [4:0]        IFID_Rs_i,
  input  logic [4:0]        IFID_Rt_i,
  input  logic              Branch_taken_i,
  input  logic              mem_req_i,
  input  logic              mem_ack_i,
  output logic              select_o,
  output logic              PCWrite_o,
  output logic              IFIDWrite_o,
  output logic              IFID_Flush_o,
  output logic              IDEXWrite_o,
  output logic              EXMEMWrite_o,
  output logic              MEMWB_bubble_o,
  output logic              mem_timeout_o,
  output logic [1:0]        state_o,
  output logic [PERF_W-1:0] stall_cycles_o,
  output logic [PERF_W-1:0] flush_count_o
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MEMWAIT = 2'd1,
    ERR     = 2'd2
  } state_t;

  state_t                state_q, state_d;
  // Down-counter of wait cycles still allowed before the watchdog fires.
  logic [WAIT_CNT_W-1:0] wait_left_q, wait_left_d;
  logic                  flush_pend_q, flush_pend_d;

  logic in_err, freeze, lduse, lduse_stall, flush;

  assign in_err      = (state_q == ERR);
  assign freeze      = ~in_err & mem_req_i & ~mem_ack_i;
  assign lduse       = IDEX_MemRd_i & (IDEX_Rt_i != 5'd0) &
                       ((IDEX_Rt_i == IFID_Rs_i) | (IDEX_Rt_i == IFID_Rt_i));
  // A frozen pipeline cannot advance, so a load-use stall only matters once
  // the freeze lifts.
  assign lduse_stall = lduse & ~freeze & ~in_err;
  assign flush       = (Branch_taken_i | flush_pend_q) & ~freeze & ~lduse_stall & ~in_err;

  assign state_o = state_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= RUN;
      wait_left_q  <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_left_q  <= wait_left_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    wait_left_d    = wait_left_q;
    flush_pend_d   = flush_pend_q;
    select_o       = 1'b0;
    PCWrite_o      = 1'b1;
    IFIDWrite_o    = 1'b1;
    IDEXWrite_o    = 1'b1;
    EXMEMWrite_o   = 1'b1;
    IFID_Flush_o   = 1'b0;
    MEMWB_bubble_o = 1'b0;
    mem_timeout_o  = 1'b0;

    case (state_q)
      RUN: begin
        if (freeze) begin
          state_d     = MEMWAIT;
          // First frozen cycle already counted: MAX_MEM_WAIT-1 more allowed.
          wait_left_d = WAIT_CNT_W'(MAX_MEM_WAIT - 1);
        end
      end
      MEMWAIT: begin
        // Ack wins over everything; a dropped request is tolerated.
        if (mem_ack_i || !mem_req_i) begin
          state_d     = RUN;
          wait_left_d = '0;
        end else if (wait_left_q == '0) begin
          state_d = ERR;
        end else begin
          wait_left_d = wait_left_q - WAIT_CNT_W'(1);
        end
      end
      ERR: state_d = ERR;
      default: begin
        state_d     = RUN;
        wait_left_d = '0;
      end
    endcase

    // A branch that cannot flush now is remembered; several collapse into one.
    if (flush) begin
      flush_pend_d = 1'b0;
    end else if (Branch_taken_i && (freeze || lduse_stall)) begin
      flush_pend_d = 1'b1;
    end

    if (rst_i) begin
      select_o     = 1'b1;
      PCWrite_o    = 1'b0;
      IFIDWrite_o  = 1'b0;
      IDEXWrite_o  = 1'b0;
      EXMEMWrite_o = 1'b0;
    end else if (in_err) begin
      select_o       = 1'b1;
      PCWrite_o      = 1'b0;
      IFIDWrite_o    = 1'b0;
      IDEXWrite_o    = 1'b0;
      EXMEMWrite_o   = 1'b0;
      MEMWB_bubble_o = 1'b1;
      mem_timeout_o  = 1'b1;
    end else if (freeze) begin
      PCWrite_o      = 1'b0;
      IFIDWrite_o    = 1'b0;
      IDEXWrite_o    = 1'b0;
      EXMEMWrite_o   = 1'b0;
      MEMWB_bubble_o = 1'b1;
    end else if (lduse_stall) begin
      select_o    = 1'b1;
      PCWrite_o   = 1'b0;
      IFIDWrite_o = 1'b0;
    end else begin
      IFID_Flush_o = flush;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [PERF_W-1:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if ((freeze || lduse_stall) && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + PERF_W'(1);
      end
      if (flush && (flush_cnt_q != '1)) begin
        flush_cnt_q <= flush_cnt_q + PERF_W'(1);
      end
    end
  end

  assign stall_cycles_o = stall_cnt_q;
  assign flush_count_o  = flush_cnt_q;
`else
  assign stall_cycles_o = '0;
  assign flush_count_o  = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;
  localparam int MAX_WAIT = 15;
  localparam int PW       = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          mem_rd = 1'b0;
  logic [4:0]    ex_rt = '0;
  logic [4:0]    id_rs = '0;
  logic [4:0]    id_rt = '0;
  logic          br = 1'b0;
  logic          req = 1'b0;
  logic          ack = 1'b0;

  logic          select_o, pc_we, ifid_we, ifid_flush, idex_we, exmem_we, memwb_bub, timeout;
  logic [1:0]    state_o;
  logic [PW-1:0] stall_cnt, flush_cnt;

  int total = 0;
  int bad   = 0;

  hazard_ctrl #(.MAX_MEM_WAIT(MAX_WAIT), .WAIT_CNT_W(4), .PERF_W(PW)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .IDEX_MemRd_i   (mem_rd),
    .IDEX_Rt_i      (ex_rt),
    .IFID_Rs_i      (id_rs),
    .IFID_Rt_i      (id_rt),
    .Branch_taken_i (br),
    .mem_req_i      (req),
    .mem_ack_i      (ack),
    .select_o       (select_o),
    .PCWrite_o      (pc_we),
    .IFIDWrite_o    (ifid_we),
    .IFID_Flush_o   (ifid_flush),
    .IDEXWrite_o    (idex_we),
    .EXMEMWrite_o   (exmem_we),
    .MEMWB_bubble_o (memwb_bub),
    .mem_timeout_o  (timeout),
    .state_o        (state_o),
    .stall_cycles_o (stall_cnt),
    .flush_count_o  (flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%b expected=%b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chkw(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: the pipeline is waiting on memory exactly when the previous cycle
  // was frozen; an error is declared after MAX_WAIT+1 consecutive frozen cycles.
  int m_streak = 0;
  bit m_err    = 1'b0;
  bit m_pend   = 1'b0;
  int m_stall  = 0;
  int m_flush  = 0;

  logic e_frz, e_ld, e_flush;
  logic e_sel, e_pc, e_ifid, e_idex, e_exmem, e_bub, e_to;
  int   e_state, e_stall, e_fcnt;

  always_comb begin
    e_frz   = !rst && !m_err && req && !ack;
    e_ld    = !rst && !m_err && !e_frz && mem_rd && (ex_rt != 5'd0) &&
              ((ex_rt == id_rs) || (ex_rt == id_rt));
    e_flush = !rst && !m_err && !e_frz && !e_ld && (br || m_pend);
    e_sel = 1'b0; e_pc = 1'b1; e_ifid = 1'b1; e_idex = 1'b1; e_exmem = 1'b1;
    e_bub = 1'b0; e_to = 1'b0;
    e_state = 0;
    if (rst) begin
      e_sel = 1'b1; e_pc = 1'b0; e_ifid = 1'b0; e_idex = 1'b0; e_exmem = 1'b0;
    end else if (m_err) begin
      e_sel = 1'b1; e_pc = 1'b0; e_ifid = 1'b0; e_idex = 1'b0; e_exmem = 1'b0;
      e_bub = 1'b1; e_to = 1'b1; e_state = 2;
    end else begin
      e_state = (m_streak > 0) ? 1 : 0;
      if (e_frz) begin
        e_pc = 1'b0; e_ifid = 1'b0; e_idex = 1'b0; e_exmem = 1'b0; e_bub = 1'b1;
      end else if (e_ld) begin
        e_sel = 1'b1; e_pc = 1'b0; e_ifid = 1'b0;
      end
    end
`ifdef HAZARD_PERF_EN
    e_stall = m_stall;
    e_fcnt  = m_flush;
`else
    e_stall = 0;
    e_fcnt  = 0;
`endif
  end

  always @(posedge clk or posedge rst) begin
    bit f, l, fl;
    f = e_frz; l = e_ld; fl = e_flush;
    if (rst) begin
      m_streak = 0; m_err = 1'b0; m_pend = 1'b0; m_stall = 0; m_flush = 0;
    end else if (!m_err) begin
      if (f) begin
        m_streak++;
        if (m_streak == MAX_WAIT + 1) m_err = 1'b1;
      end else begin
        m_streak = 0;
      end
      if (fl) m_pend = 1'b0;
      else if (br && (f || l)) m_pend = 1'b1;
      if ((f || l) && m_stall < 65535) m_stall++;
      if (fl && m_flush < 65535) m_flush++;
    end
  end

  always @(negedge clk) begin
    chk1("select", select_o, e_sel);
    chk1("pcwrite", pc_we, e_pc);
    chk1("ifidwrite", ifid_we, e_ifid);
    chk1("idexwrite", idex_we, e_idex);
    chk1("exmemwrite", exmem_we, e_exmem);
    chk1("memwb_bubble", memwb_bub, e_bub);
    chk1("ifid_flush", ifid_flush, e_flush);
    chk1("timeout", timeout, e_to);
    chkw("state", int'(state_o), e_state);
    chkw("stall_cycles", int'(stall_cnt), e_stall);
    chkw("flush_count", int'(flush_cnt), e_fcnt);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    #2;
  endtask

  initial begin
    #2;
    chk1("rst_select", select_o, 1'b1);
    chk1("rst_pcwrite", pc_we, 1'b0);
    chkw("rst_state", int'(state_o), 0);
    chk1("rst_timeout", timeout, 1'b0);
    repeat (2) step();
    rst = 1'b0;
    look();
    chk1("run_pcwrite", pc_we, 1'b1);
    chk1("run_select", select_o, 1'b0);

    // load-use, then the same pattern on r0
    step(); mem_rd = 1'b1; ex_rt = 5'd5; id_rs = 5'd5; look();
    chk1("lduse_select", select_o, 1'b1);
    chk1("lduse_pcwrite", pc_we, 1'b0);
    chk1("lduse_ifidwrite", ifid_we, 1'b0);
    chk1("lduse_idexwrite", idex_we, 1'b1);
    step(); ex_rt = 5'd0; id_rs = 5'd0; look();
    chk1("r0_pcwrite", pc_we, 1'b1);
    chk1("r0_select", select_o, 1'b0);

    // memory wait acked after 3 frozen cycles
    step(); mem_rd = 1'b0; req = 1'b1; look();
    chk1("wait1_pcwrite", pc_we, 1'b0);
    chk1("wait1_bubble", memwb_bub, 1'b1);
    chkw("wait1_state", int'(state_o), 0);
    step(); look();
    chkw("wait2_state", int'(state_o), 1);
    step();
    step(); ack = 1'b1; look();
    chkw("ack_state", int'(state_o), 1);
    chk1("ack_pcwrite", pc_we, 1'b1);
    chk1("ack_bubble", memwb_bub, 1'b0);
    step(); req = 1'b0; ack = 1'b0; br = 1'b1; look();
    chk1("br1_flush", ifid_flush, 1'b1);
    chkw("after_ack_state", int'(state_o), 0);
    step(); br = 1'b0;
    step(); br = 1'b1; look();
    chk1("br2_flush", ifid_flush, 1'b1);
    step(); br = 1'b0; look();
`ifdef HAZARD_PERF_EN
    chkw("perf_stall", int'(stall_cnt), 4);
    chkw("perf_flush", int'(flush_cnt), 2);
`else
    chkw("perf_stall_off", int'(stall_cnt), 0);
    chkw("perf_flush_off", int'(flush_cnt), 0);
`endif

    // branch during freeze, second branch on the ack cycle collapses
    step(); req = 1'b1;
    step(); br = 1'b1; look();
    chk1("frz_br_flush", ifid_flush, 1'b0);
    step(); br = 1'b0;
    step(); ack = 1'b1; br = 1'b1; look();
    chk1("unfrz_flush", ifid_flush, 1'b1);
    chk1("unfrz_pcwrite", pc_we, 1'b1);
    step(); req = 1'b0; ack = 1'b0; br = 1'b0; look();
    chk1("single_flush", ifid_flush, 1'b0);

    // branch during load-use
    step(); mem_rd = 1'b1; ex_rt = 5'd7; id_rt = 5'd7; br = 1'b1; look();
    chk1("ld_br_flush", ifid_flush, 1'b0);
    chk1("ld_br_select", select_o, 1'b1);
    step(); mem_rd = 1'b0; ex_rt = 5'd0; id_rt = 5'd0; br = 1'b0; look();
    chk1("pend_flush", ifid_flush, 1'b1);
    step(); look();
    chk1("pend_clear", ifid_flush, 1'b0);

    // request dropped without ack
    step(); req = 1'b1; look();
    chk1("drop1_pcwrite", pc_we, 1'b0);
    step(); req = 1'b0; look();
    chkw("drop2_state", int'(state_o), 1);
    chk1("drop2_pcwrite", pc_we, 1'b1);
    step(); look();
    chkw("drop3_state", int'(state_o), 0);

    // async reset in the middle of a wait
    step(); req = 1'b1;
    step();
    step(); look();
    chkw("pre_rst_state", int'(state_o), 1);
    rst = 1'b1;
    #1;
    chkw("async_rst_state", int'(state_o), 0);
    chk1("async_rst_pcwrite", pc_we, 1'b0);
    chk1("async_rst_select", select_o, 1'b1);
    step(); rst = 1'b0; req = 1'b0; look();
    chk1("post_rst_pcwrite", pc_we, 1'b1);
    chkw("post_rst_stall", int'(stall_cnt), 0);
    chkw("post_rst_flush", int'(flush_cnt), 0);

    // timeout
    step(); req = 1'b1;
    repeat (MAX_WAIT) step();
    look();
    chkw("to_last_wait_state", int'(state_o), 1);
    step(); look();
    chkw("to_state", int'(state_o), 2);
    chk1("to_flag", timeout, 1'b1);
    chk1("to_select", select_o, 1'b1);
    step(); req = 1'b0; mem_rd = 1'b1; ex_rt = 5'd3; id_rs = 5'd3; br = 1'b1;
    repeat (3) step();
    look();
    chkw("err_sticky_state", int'(state_o), 2);
    chk1("err_sticky_flag", timeout, 1'b1);
    chk1("err_no_flush", ifid_flush, 1'b0);
    chk1("err_pcwrite", pc_we, 1'b0);
    chk1("err_bubble", memwb_bub, 1'b1);
    step(); rst = 1'b1; mem_rd = 1'b0; ex_rt = '0; id_rs = '0; br = 1'b0; look();
    chkw("err_rst_state", int'(state_o), 0);
    chk1("err_rst_flag", timeout, 1'b0);
    step(); rst = 1'b0; look();
    chk1("final_pcwrite", pc_we, 1'b1);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
